// File: rtl/lifo_pop_reader_if.sv
// Purpose : bundles the LIFO pop port and the downstream valid/ready stream
//           of lifo_pop_reader into one interface.
// Signals : lifo_read  - pop strobe to the LIFO (reader -> LIFO)
//           lifo_empty - LIFO empty flag (LIFO -> reader)
//           lifo_data  - LIFO data_out, valid the cycle after a pop
//           m_valid    - downstream word valid (reader -> sink)
//           m_ready    - downstream accept (sink -> reader)
//           m_data     - downstream word (reader -> sink)
// Modports: master = the reader, slave = LIFO plus downstream sink.
interface lifo_pop_reader_if #(
  parameter int unsigned DATA_W = 8
) ();

  logic              lifo_read;
  logic              lifo_empty;
  logic [DATA_W-1:0] lifo_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;

  modport master (
    output lifo_read,
    input  lifo_empty,
    input  lifo_data,
    output m_valid,
    input  m_ready,
    output m_data
  );

  modport slave (
    input  lifo_read,
    output lifo_empty,
    output lifo_data,
    input  m_valid,
    output m_ready,
    input  m_data
  );

endinterface

// File: rtl/lifo_pop_reader.sv
// Purpose : pops a commanded number of words from a LIFO, one at a time, and
//           forwards each over a valid/ready stream. A burst stops early if
//           the LIFO runs empty. At most one pop is outstanding.
// Ports   : clk        - rising-edge clock
//           reset      - synchronous active-high reset
//           start      - one-cycle command strobe, accepted only when idle
//           count      - words to pop, sampled with an accepted start
//           bus        - LIFO pop port and downstream stream (master side)
//           busy       - burst in progress
//           done       - one-cycle end-of-burst pulse
//           short      - burst ended early on lifo_empty; held until next start
//           popped     - words delivered in the current or last burst
module lifo_pop_reader #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  count,
  lifo_pop_reader_if.master bus,
  output logic              busy,
  output logic              done,
  output logic              short,
  output logic [CNT_W-1:0]  popped
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_POP  = 3'd1,
    S_CAPT = 3'd2,
    S_OUT  = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t            r_state;
  logic              r_lifo_read;
  logic              r_m_valid;
  logic [DATA_W-1:0] r_m_data;
  logic              r_busy;
  logic              r_done;
  logic              r_short;
  logic [CNT_W-1:0]  r_popped;
  logic [CNT_W-1:0]  r_remaining;

  logic              w_handshake;
  logic              w_last;
  logic              w_count_zero;

  assign w_handshake  = r_m_valid & bus.m_ready;
  assign w_last       = (r_remaining == CNT_W'(1));
  assign w_count_zero = (count == '0);

  // Burst sequencer. The pop strobe is registered on the edge that enters
  // POP, so the empty flag is judged at that edge and lifo_read is high for
  // exactly the POP cycle. POP then only reports whether a pop was issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_lifo_read <= 1'b0;
      r_m_valid   <= 1'b0;
      r_m_data    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_short     <= 1'b0;
      r_popped    <= '0;
      r_remaining <= '0;
    end else begin
      r_lifo_read <= 1'b0;
      r_done      <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_remaining <= count;
            r_popped    <= '0;
            r_short     <= 1'b0;
            r_busy      <= 1'b1;
            if (w_count_zero) begin
              r_state <= S_FIN;
            end else begin
              r_state     <= S_POP;
              r_lifo_read <= ~bus.lifo_empty;
            end
          end
        end

        S_POP: begin
          if (r_lifo_read) begin
            r_state <= S_CAPT;
          end else begin
            // LIFO was empty when the pop was due: end the burst early.
            r_short <= 1'b1;
            r_state <= S_FIN;
          end
        end

        S_CAPT: begin
          r_m_data  <= bus.lifo_data;
          r_m_valid <= 1'b1;
          r_state   <= S_OUT;
        end

        S_OUT: begin
          if (w_handshake) begin
            r_m_valid   <= 1'b0;
            r_popped    <= r_popped + CNT_W'(1);
            r_remaining <= r_remaining - CNT_W'(1);
            if (w_last) begin
              r_state <= S_FIN;
            end else begin
              r_state     <= S_POP;
              r_lifo_read <= ~bus.lifo_empty;
            end
          end
        end

        S_FIN: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.lifo_read = r_lifo_read;
  assign bus.m_valid   = r_m_valid;
  assign bus.m_data    = r_m_data;
  assign busy          = r_busy;
  assign done          = r_done;
  assign short         = r_short;
  assign popped        = r_popped;

endmodule

// File: tb/tb_lifo_pop_reader.sv
// Testbench for lifo_pop_reader: a behavioural LIFO drives the pop port,
// a word-stack reference model predicts every delivered word and burst result.
module tb_lifo_pop_reader;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 8;

  typedef struct {
    string name;
    int    nload;
    int    cnt;
    int    rpct;
    int    exp_popped;
    bit    exp_short;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [CNT_W-1:0]  count;
  logic              busy;
  logic              done;
  logic              short_o;
  logic [CNT_W-1:0]  popped;

  lifo_pop_reader_if #(.DATA_W(DATA_W)) bus ();

  lifo_pop_reader #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .count  (count),
    .bus    (bus),
    .busy   (busy),
    .done   (done),
    .short  (short_o),
    .popped (popped)
  );

  always #5 clk = ~clk;

  // Behavioural LIFO: data_out updates on the edge that samples lifo_read.
  logic [DATA_W-1:0] stk [64];
  int                sp = 0;
  int                rd_cnt = 0;
  int                rd_empty_err = 0;
  logic              push_en = 1'b0;
  logic              clr = 1'b0;
  logic [DATA_W-1:0] push_data = '0;

  assign bus.lifo_empty = (sp == 0);

  always @(posedge clk) begin
    if (clr) sp <= 0;
    else if (push_en) begin
      stk[sp] <= push_data;
      sp      <= sp + 1;
    end
    if (bus.lifo_read) begin
      rd_cnt <= rd_cnt + 1;
      if (sp == 0) rd_empty_err <= rd_empty_err + 1;
      else begin
        bus.lifo_data <= stk[sp-1];
        sp            <= sp - 1;
      end
    end
  end

  // Reference model: the LIFO contents as a queue, top at the back.
  logic [DATA_W-1:0] ref_stack [$];
  logic [DATA_W-1:0] base [8] = '{8'd2, 8'd4, 8'd6, 8'd8, 8'd10, 8'd12, 8'd16, 8'd18};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic clear_lifo();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    ref_stack.delete();
  endtask

  task automatic push_word(input logic [DATA_W-1:0] v);
    push_en   = 1'b1;
    push_data = v;
    @(negedge clk);
    push_en = 1'b0;
    ref_stack.push_back(v);
  endtask

  // One burst from IDLE to done, with random back-pressure and optional
  // start pokes while busy; every accepted word is checked against the model.
  task automatic run_burst(input int cnt, input int rpct, input bit poke, input string name,
                           output int got_popped, output bit got_short);
    int                exp_n;
    bit                exp_short;
    int                got;
    int                cyc;
    int                rd0;
    bit                hold;
    logic [DATA_W-1:0] hold_data;
    logic [DATA_W-1:0] exp_w;
    exp_n     = (cnt < ref_stack.size()) ? cnt : ref_stack.size();
    exp_short = (cnt > ref_stack.size());
    rd0  = rd_cnt;
    got  = 0;
    cyc  = 0;
    hold = 1'b0;
    hold_data = '0;
    start = 1'b1;
    count = CNT_W'(cnt);
    @(negedge clk);
    start = 1'b0;
    chk({name, " busy"}, busy, 1);
    while (!done && cyc < 3000) begin
      if (hold) begin
        chk({name, " hold valid"}, bus.m_valid, 1);
        chk({name, " hold data"}, bus.m_data, hold_data);
        chk({name, " hold no read"}, bus.lifo_read, 0);
      end
      bus.m_ready = (int'($urandom_range(99)) < rpct);
      if (poke) begin
        start = ($urandom_range(3) == 0);
        count = CNT_W'(7);
      end
      if (bus.m_valid && bus.m_ready) begin
        got++;
        if (ref_stack.size() == 0) chk({name, " extra word"}, got, exp_n);
        else begin
          exp_w = ref_stack.pop_back();
          chk({name, " word"}, bus.m_data, exp_w);
        end
      end
      hold      = bus.m_valid && !bus.m_ready;
      hold_data = bus.m_data;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    bus.m_ready = 1'b0;
    chk({name, " done in time"}, (cyc < 3000), 1);
    chk({name, " short"}, short_o, exp_short);
    chk({name, " popped"}, popped, exp_n);
    chk({name, " words"}, got, exp_n);
    chk({name, " reads"}, rd_cnt - rd0, exp_n);
    chk({name, " read empty"}, rd_empty_err, 0);
    chk({name, " busy at done"}, busy, 0);
    got_popped = int'(popped);
    got_short  = short_o;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs [7];
    int   gp;
    bit   gs;
    int   rd0;
    int   hs;
    int   cyc;

    vecs[0] = '{"full8",   8,  8, 100, 8, 1'b0};
    vecs[1] = '{"over10",  8, 10, 100, 8, 1'b1};
    vecs[2] = '{"zero",    8,  0, 100, 0, 1'b0};
    vecs[3] = '{"part3",   8,  3,  50, 3, 1'b0};
    vecs[4] = '{"empty2",  0,  2, 100, 0, 1'b1};
    vecs[5] = '{"one1",    1,  1,  30, 1, 1'b0};
    vecs[6] = '{"five6",   5,  6,  70, 5, 1'b1};

    reset = 1'b1;
    start = 1'b0;
    count = '0;
    bus.m_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst lifo_read", bus.lifo_read, 0);
    chk("rst m_valid", bus.m_valid, 0);
    chk("rst m_data", bus.m_data, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst short", short_o, 0);
    chk("rst popped", popped, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      clear_lifo();
      for (int j = 0; j < vecs[i].nload; j++) push_word(base[j]);
      run_burst(vecs[i].cnt, vecs[i].rpct, 1'b0, vecs[i].name, gp, gs);
      chk({vecs[i].name, " tbl popped"}, gp, vecs[i].exp_popped);
      chk({vecs[i].name, " tbl short"}, gs, vecs[i].exp_short);
      @(negedge clk);
    end

    // Latency from start, five-cycle stall, then completion timing.
    clear_lifo();
    for (int j = 0; j < 3; j++) push_word(base[j]);
    rd0 = rd_cnt;
    bus.m_ready = 1'b0;
    start = 1'b1;
    count = CNT_W'(1);
    @(negedge clk);
    start = 1'b0;
    chk("lat read k", bus.lifo_read, 1);
    chk("lat busy k", busy, 1);
    chk("lat valid k", bus.m_valid, 0);
    @(negedge clk);
    chk("lat read k+1", bus.lifo_read, 0);
    chk("lat valid k+1", bus.m_valid, 0);
    @(negedge clk);
    chk("lat valid k+2", bus.m_valid, 1);
    chk("lat data k+2", bus.m_data, 6);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk("stall valid", bus.m_valid, 1);
      chk("stall data", bus.m_data, 6);
      chk("stall no read", bus.lifo_read, 0);
    end
    bus.m_ready = 1'b1;
    @(negedge clk);
    bus.m_ready = 1'b0;
    chk("fin valid", bus.m_valid, 0);
    chk("fin busy", busy, 1);
    chk("fin done early", done, 0);
    @(negedge clk);
    chk("fin done", done, 1);
    chk("fin busy off", busy, 0);
    chk("fin popped", popped, 1);
    chk("fin short", short_o, 0);
    @(negedge clk);
    chk("fin done pulse", done, 0);
    chk("fin reads", rd_cnt - rd0, 1);
    void'(ref_stack.pop_back());

    // count=0: done two cycles after start, no pop.
    rd0 = rd_cnt;
    start = 1'b1;
    count = CNT_W'(0);
    @(negedge clk);
    start = 1'b0;
    chk("z read", bus.lifo_read, 0);
    chk("z busy", busy, 1);
    chk("z done early", done, 0);
    @(negedge clk);
    chk("z done", done, 1);
    chk("z busy off", busy, 0);
    chk("z popped", popped, 0);
    chk("z reads", rd_cnt - rd0, 0);

    // Reset while the fourth word is held: it is dropped, four words remain.
    clear_lifo();
    for (int j = 0; j < 8; j++) push_word(base[j]);
    rd0 = rd_cnt;
    start = 1'b1;
    count = CNT_W'(8);
    bus.m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hs = 0;
    cyc = 0;
    while (hs < 3 && cyc < 200) begin
      if (bus.m_valid && bus.m_ready) hs++;
      if (hs < 3) @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    bus.m_ready = 1'b0;
    cyc = 0;
    while (!bus.m_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid handshakes", hs, 3);
    chk("mid held", bus.m_valid, 1);
    chk("mid data", bus.m_data, 10);
    reset = 1'b1;
    start = 1'b1;
    count = CNT_W'(5);
    @(negedge clk);
    chk("mid rst read", bus.lifo_read, 0);
    chk("mid rst valid", bus.m_valid, 0);
    chk("mid rst data", bus.m_data, 0);
    chk("mid rst busy", busy, 0);
    chk("mid rst done", done, 0);
    chk("mid rst short", short_o, 0);
    chk("mid rst popped", popped, 0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("rst start ignored", busy, 0);
    chk("mid lifo left", sp, 4);
    chk("mid reads", rd_cnt - rd0, 4);
    ref_stack.delete();
    for (int j = 0; j < 4; j++) ref_stack.push_back(base[j]);
    run_burst(5, 100, 1'b0, "resume", gp, gs);
    chk("resume popped", gp, 4);
    chk("resume short", gs, 1);
    @(negedge clk);

    // Start pulsed while busy must not change the latched count.
    clear_lifo();
    for (int j = 0; j < 8; j++) push_word(base[j]);
    run_burst(3, 60, 1'b1, "poke", gp, gs);
    chk("poke popped", gp, 3);
    @(negedge clk);

    // Randomized bursts; LIFO contents carry over between bursts.
    clear_lifo();
    for (int t = 0; t < 25; t++) begin
      int nl;
      nl = int'($urandom_range(6));
      if (ref_stack.size() > 40) clear_lifo();
      for (int j = 0; j < nl; j++) push_word(DATA_W'($urandom_range(255)));
      run_burst(int'($urandom_range(12)), int'($urandom_range(100, 20)),
                bit'($urandom_range(1)), "rand", gp, gs);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
